controle_mapa: RTL and testbench

Sequencing controller for the map multiplexer `mux_mapa`. It lets the player step through the four stored maps with a "next" button and lock one in with a "confirm" button. It drives the multiplexer's 2-bit select and latches the selected 7-bit map for the game logic. A blink enable lets the display flash the map being previewed, and an end-of-game pulse returns the block to selection.

---
 rtl/controle_mapa_pkg.sv | 14 +
 rtl/controle_mapa_sync.sv | 38 +++
 rtl/controle_mapa.sv | 114 +++++++++++
 tb/tb_controle_mapa.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_mapa_pkg.sv
// controle_mapa shared types and constants.
// Map width and count are also used by mux_mapa.
package controle_mapa_pkg;

  typedef enum logic {
    SELECAO = 1'b0,
    JOGO    = 1'b1
  } estado_e;

  localparam int N_MAPAS = 4;
  localparam int MAPA_W  = 7;
  localparam int SEL_W   = $clog2(N_MAPAS);

endpackage

// File: rtl/controle_mapa_sync.sv
// Button synchronizer with rising-edge detection.
// One pulse per press, none for a button held through reset.
module sincroniza_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulso
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic v1_q;
  logic v2_q;
  logic arm_q;

  // arm only once s2 holds a real low sample, not the reset zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      s1_q  <= in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      v1_q  <= 1'b1;
      v2_q  <= v1_q;
      arm_q <= arm_q | (v2_q & ~s2_q);
    end
  end

  assign pulso = arm_q & s2_q & ~s3_q;

endmodule

// File: rtl/controle_mapa.sv
// Map selection controller: steps sel, latches confirmed map,
// blinks the preview and returns to selection at end of game.
module controle_mapa
  import controle_mapa_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_prox,
  input  logic              btn_conf,
  input  logic              fim_jogo,
  input  logic [MAPA_W-1:0] mapa_in,
  output logic [SEL_W-1:0]  sel,
  output logic [MAPA_W-1:0] mapa_reg,
  output logic              mapa_valido,
  output logic              pronto,
  output logic              pisca
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic prox_ev;
  logic conf_ev;

  estado_e           estado_q, estado_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [MAPA_W-1:0] mapa_q, mapa_d;
  logic              pronto_q, pronto_d;
  logic              pisca_q, pisca_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  sincroniza_borda u_sync_prox (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (btn_prox),
    .pulso (prox_ev)
  );

  sincroniza_borda u_sync_conf (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (btn_conf),
    .pulso (conf_ev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= SELECAO;
      sel_q    <= '0;
      mapa_q   <= '0;
      pronto_q <= 1'b0;
      pisca_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      sel_q    <= sel_d;
      mapa_q   <= mapa_d;
      pronto_q <= pronto_d;
      pisca_q  <= pisca_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    sel_d    = sel_q;
    mapa_d   = mapa_q;
    pronto_d = 1'b0;
    pisca_d  = pisca_q;
    cnt_d    = cnt_q;
    unique case (estado_q)
      SELECAO: begin
        if (conf_ev) begin
          // confirm wins over a same-cycle next
          estado_d = JOGO;
          mapa_d   = mapa_in;
          pronto_d = 1'b1;
          pisca_d  = 1'b0;
          cnt_d    = '0;
        end else begin
          if (prox_ev) begin
            sel_d = sel_q + SEL_W'(1);
          end
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            pisca_d = ~pisca_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      JOGO: begin
        cnt_d   = '0;
        pisca_d = 1'b0;
        if (fim_jogo) begin
          estado_d = SELECAO;
          pisca_d  = 1'b1;
        end
      end
      default: begin
        estado_d = SELECAO;
      end
    endcase
  end

  assign sel         = sel_q;
  assign mapa_reg    = mapa_q;
  assign mapa_valido = (estado_q == JOGO);
  assign pronto      = pronto_q;
  assign pisca       = pisca_q;

endmodule

// File: tb/tb_controle_mapa.sv
// Directed bench for controle_mapa with BLINK_DIV=4
// and a behavioral mux_mapa.
module tb_controle_mapa;

  localparam int BD = 4;
  localparam logic [6:0] MAPS [4] = '{
    7'b1000001, 7'b1100011, 7'b1110111, 7'b1111001
  };
  localparam bit PIS [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_prox = 1'b0;
  logic       btn_conf = 1'b0;
  logic       fim_jogo = 1'b0;
  logic [6:0] mapa_in;
  logic [1:0] sel;
  logic [6:0] mapa_reg;
  logic       mapa_valido;
  logic       pronto;
  logic       pisca;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       prox;
    logic       conf;
    logic       fim;
    logic [1:0] sel;
    logic [6:0] mapa;
    logic       val;
    logic       pr;
    logic       pis;
  } vec_t;

  vec_t tbl [10];

  controle_mapa #(.BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_prox    (btn_prox),
    .btn_conf    (btn_conf),
    .fim_jogo    (fim_jogo),
    .mapa_in     (mapa_in),
    .sel         (sel),
    .mapa_reg    (mapa_reg),
    .mapa_valido (mapa_valido),
    .pronto      (pronto),
    .pisca       (pisca)
  );

  always_comb mapa_in = MAPS[sel];

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act,
                      input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk7(input string nm, input logic [6:0] act,
                      input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk2({nm, "_sel"}, sel, 2'd0);
    chk7({nm, "_mapa"}, mapa_reg, 7'd0);
    chk1({nm, "_valido"}, mapa_valido, 1'b0);
    chk1({nm, "_pronto"}, pronto, 1'b0);
    chk1({nm, "_pisca"}, pisca, 1'b1);
  endtask

  // call at a negedge; returns at a negedge
  task automatic press_prox(input logic [1:0] old_v, input logic [1:0] new_v,
                            input string nm);
    btn_prox = 1'b1;
    tick();
    tick();
    chk2({nm, "_before"}, sel, old_v);
    tick();
    chk2({nm, "_after"}, sel, new_v);
    repeat (2) @(negedge clk);
    btn_prox = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_btn(input logic p, input logic c);
    btn_prox = p;
    btn_conf = c;
    repeat (4) @(negedge clk);
    btn_prox = 1'b0;
    btn_conf = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].prox = 1'b0;
      tbl[i].conf = 1'b0;
      tbl[i].fim  = (i == 5);
      tbl[i].sel  = 2'd0;
      tbl[i].mapa = 7'd0;
      tbl[i].val  = 1'b0;
      tbl[i].pr   = 1'b0;
      tbl[i].pis  = PIS[i];
    end

    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      btn_prox = tbl[i].prox;
      btn_conf = tbl[i].conf;
      fim_jogo = tbl[i].fim;
      @(posedge clk);
      #1;
      chk2($sformatf("idle%0d_sel", i), sel, tbl[i].sel);
      chk7($sformatf("idle%0d_mapa", i), mapa_reg, tbl[i].mapa);
      chk1($sformatf("idle%0d_valido", i), mapa_valido, tbl[i].val);
      chk1($sformatf("idle%0d_pronto", i), pronto, tbl[i].pr);
      chk1($sformatf("idle%0d_pisca", i), pisca, tbl[i].pis);
      @(negedge clk);
    end
    fim_jogo = 1'b0;

    press_prox(2'd0, 2'd1, "prox1");
    press_prox(2'd1, 2'd2, "prox2");
    press_prox(2'd2, 2'd3, "prox3");
    press_prox(2'd3, 2'd0, "prox4");
    press_prox(2'd0, 2'd1, "prox5");
    press_prox(2'd1, 2'd2, "prox6");

    btn_conf = 1'b1;
    tick();
    tick();
    chk1("conf_early_valido", mapa_valido, 1'b0);
    chk1("conf_early_pronto", pronto, 1'b0);
    tick();
    chk7("conf_mapa", mapa_reg, 7'b1110111);
    chk1("conf_valido", mapa_valido, 1'b1);
    chk1("conf_pronto", pronto, 1'b1);
    chk1("conf_pisca", pisca, 1'b0);
    chk2("conf_sel", sel, 2'd2);
    tick();
    chk1("conf_pronto_drop", pronto, 1'b0);
    chk1("conf_valido_hold", mapa_valido, 1'b1);
    @(negedge clk);
    btn_conf = 1'b0;
    repeat (4) @(negedge clk);

    pulse_btn(1'b1, 1'b0);
    chk2("jogo_prox_sel", sel, 2'd2);
    chk1("jogo_valido", mapa_valido, 1'b1);
    chk1("jogo_pisca", pisca, 1'b0);

    fim_jogo = 1'b1;
    tick();
    fim_jogo = 1'b0;
    chk1("fim1_valido", mapa_valido, 1'b0);
    chk1("fim1_pisca", pisca, 1'b1);
    chk2("fim1_sel", sel, 2'd2);
    chk7("fim1_mapa", mapa_reg, 7'b1110111);
    @(negedge clk);

    press_prox(2'd2, 2'd3, "prox7");

    btn_prox = 1'b1;
    btn_conf = 1'b1;
    tick();
    tick();
    chk1("both_early_valido", mapa_valido, 1'b0);
    tick();
    chk7("both_mapa", mapa_reg, 7'b1111001);
    chk2("both_sel", sel, 2'd3);
    chk1("both_valido", mapa_valido, 1'b1);
    chk1("both_pronto", pronto, 1'b1);
    repeat (2) @(negedge clk);
    btn_prox = 1'b0;
    btn_conf = 1'b0;
    repeat (4) @(negedge clk);
    chk2("both_sel_hold", sel, 2'd3);

    fim_jogo = 1'b1;
    tick();
    fim_jogo = 1'b0;
    chk1("fim2_valido", mapa_valido, 1'b0);
    chk1("fim2_pisca", pisca, 1'b1);
    chk2("fim2_sel", sel, 2'd3);
    tick();
    tick();
    tick();
    chk1("fim2_pisca_k3", pisca, 1'b1);
    tick();
    chk1("fim2_pisca_k4", pisca, 1'b0);
    @(negedge clk);

    press_prox(2'd3, 2'd0, "prox_wrap");

    fim_jogo = 1'b1;
    tick();
    fim_jogo = 1'b0;
    chk1("fim_sel_valido", mapa_valido, 1'b0);
    chk2("fim_sel_sel", sel, 2'd0);
    chk7("fim_sel_mapa", mapa_reg, 7'b1111001);
    @(negedge clk);

    pulse_btn(1'b0, 1'b1);
    chk1("conf2_valido", mapa_valido, 1'b1);
    chk7("conf2_mapa", mapa_reg, 7'b1000001);

    btn_prox = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) tick();
    chk2("held_sel", sel, 2'd0);
    chk1("held_valido", mapa_valido, 1'b0);
    chk7("held_mapa", mapa_reg, 7'd0);
    @(negedge clk);
    btn_prox = 1'b0;
    repeat (4) @(negedge clk);
    press_prox(2'd0, 2'd1, "prox_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
